// File: rtl/fpu_result_queue.sv
// fpu_result_queue: canonicalizes and classifies FP add/sub results, buffers them
// in a small FIFO for register-file writeback and keeps sticky status flags.
module fpu_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_y,
    input  logic                     in_ovf,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [9:0]               out_cls,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     flags_clr,
    output logic                     flag_of,
    output logic                     flag_nv
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [31:0]      mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic [9:0]       mem_cls  [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic          push;
    logic          pop;

    logic          sgn;
    logic [7:0]    ex;
    logic [22:0]   mt;
    logic          exp_max;
    logic          exp_zero;
    logic          man_zero;
    logic          is_nan;
    logic [31:0]   in_data;
    logic [9:0]    in_cls;

    assign sgn      = in_y[31];
    assign ex       = in_y[30:23];
    assign mt       = in_y[22:0];
    assign exp_max  = &ex;
    assign exp_zero = ~|ex;
    assign man_zero = ~|mt;
    assign is_nan   = exp_max && !man_zero;

    // Handshake: in_ready looks only at registered occupancy, no full-queue pass-through.
    assign in_ready  = rstn && (count < DEPTH_CNT);
    assign push      = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // Write-path transform: canonical data and one-hot class for the incoming result.
    always_comb begin
        in_data = in_y;
        in_cls  = '0;
        if (in_ovf) begin
            in_data = {sgn, 8'hFF, 23'b0};
            in_cls  = sgn ? 10'h001 : 10'h080;
        end else if (is_nan) begin
            in_data = 32'h7FC0_0000;
            in_cls  = mt[22] ? 10'h200 : 10'h100;
        end else if (exp_max) begin
            in_cls  = sgn ? 10'h001 : 10'h080;
        end else if (exp_zero && man_zero) begin
            in_cls  = sgn ? 10'h008 : 10'h010;
        end else if (exp_zero) begin
            in_cls  = sgn ? 10'h004 : 10'h020;
        end else begin
            in_cls  = sgn ? 10'h002 : 10'h040;
        end
    end

    // Entry storage: written on push only, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr] <= in_data;
            mem_tag[wptr]  <= in_tag;
            mem_cls[wptr]  <= in_cls;
        end
    end

    // Pointers, occupancy and sticky flags; a setting push beats flags_clr.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            flag_of <= 1'b0;
            flag_nv <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            flag_of <= (flag_of && !flags_clr) || (push && in_ovf);
            flag_nv <= (flag_nv && !flags_clr) || (push && is_nan);
        end
    end

    // Read mux: head entry, zeroed while the queue is empty.
    always_comb begin
        out_data = '0;
        out_tag  = '0;
        out_cls  = '0;
        if (out_valid) begin
            out_data = mem_data[rptr];
            out_tag  = mem_tag[rptr];
            out_cls  = mem_cls[rptr];
        end
    end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Self-checking bench for fpu_result_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_fpu_result_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_y;
    logic              in_ovf;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [9:0]        out_cls;
    logic [$clog2(DEPTH):0] count;
    logic              flags_clr;
    logic              flag_of;
    logic              flag_nv;

    always #5 clk = ~clk;

    fpu_result_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_ovf    (in_ovf),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_cls   (out_cls),
        .count     (count),
        .flags_clr (flags_clr),
        .flag_of   (flag_of),
        .flag_nv   (flag_nv)
    );

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        logic [9:0]       c;
    } ent_t;

    ent_t mq[$];
    bit   m_of;
    bit   m_nv;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference transform: magnitude kind 0..3 (zero, sub, normal, inf) mirrored around sign.
    function automatic ent_t xform(input logic [31:0] y, input logic ovf, input logic [TAG_W-1:0] t);
        ent_t e;
        int   k;
        int   idx;
        int   ex;
        int   fr;
        ex  = int'(y[30:23]);
        fr  = int'(y[22:0]);
        e.t = t;
        e.d = y;
        if (ovf) begin
            e.d = y[31] ? 32'hFF80_0000 : 32'h7F80_0000;
            idx = y[31] ? 0 : 7;
        end else if (ex == 255 && fr != 0) begin
            e.d = 32'h7FC0_0000;
            idx = (fr >= (1 << 22)) ? 9 : 8;
        end else begin
            if (ex == 255)     k = 3;
            else if (ex != 0)  k = 2;
            else if (fr != 0)  k = 1;
            else               k = 0;
            idx = y[31] ? (3 - k) : (4 + k);
        end
        e.c = 10'(1 << idx);
        return e;
    endfunction

    function automatic bit nan_of(input logic [31:0] y);
        return (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    endfunction

    task automatic compare_all();
        bit v;
        v = (mq.size() != 0);
        check("in_ready",  32'(in_ready),  32'(rstn && (mq.size() < DEPTH)));
        check("out_valid", 32'(out_valid), 32'(v));
        check("count",     32'(count),     32'(mq.size()));
        check("out_data",  out_data,       v ? mq[0].d : 32'd0);
        check("out_tag",   32'(out_tag),   v ? 32'(mq[0].t) : 32'd0);
        check("out_cls",   32'(out_cls),   v ? 32'(mq[0].c) : 32'd0);
        check("flag_of",   32'(flag_of),   32'(m_of));
        check("flag_nv",   32'(flag_nv),   32'(m_nv));
    endtask

    task automatic model_step();
        bit psh;
        bit pp;
        if (!rstn) begin
            mq.delete();
            m_of = 0;
            m_nv = 0;
        end else begin
            psh = in_valid && (mq.size() < DEPTH);
            pp  = out_ready && (mq.size() != 0);
            if (pp) void'(mq.pop_front());
            if (psh) mq.push_back(xform(in_y, in_ovf, in_tag));
            if (flags_clr) begin
                m_of = 0;
                m_nv = 0;
            end
            if (psh && in_ovf) m_of = 1;
            if (psh && nan_of(in_y)) m_nv = 1;
        end
    endtask

    // Check outputs mid-cycle, advance the model, then let the edge happen.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] y, input logic ovf,
                         input logic [TAG_W-1:0] t, input logic ordy, input logic clr,
                         input logic rst);
        in_valid  = v;
        in_y      = y;
        in_ovf    = ovf;
        in_tag    = t;
        out_ready = ordy;
        flags_clr = clr;
        rstn      = rst;
    endtask

    task automatic drain();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b0, 32'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
            cycle();
        end
    endtask

    function automatic logic [31:0] pick_y();
        logic [31:0] r;
        logic        s;
        r = $urandom;
        s = r[31];
        case ($urandom_range(0, 7))
            0: pick_y = {s, 8'hFF, 23'd0};
            1: pick_y = {s, 8'hFF, 1'b1, r[21:0]};
            2: pick_y = {s, 8'hFF, 1'b0, r[21:1], 1'b1};
            3: pick_y = {s, 31'd0};
            4: pick_y = {s, 8'h00, r[22:1], 1'b1};
            default: pick_y = r;
        endcase
    endfunction

    initial begin
        drive(1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cycle();

        // First push: appears one cycle later, positive normal
        drive(1'b1, 32'h3F80_0000, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
        cycle();
        check("t1_count", 32'(count), 32'd1);
        check("t1_data", out_data, 32'h3F80_0000);
        check("t1_tag", 32'(out_tag), 32'd3);
        check("t1_cls", 32'(out_cls), 32'h040);
        drain();

        // Fill, overfill attempt, then pop in order
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h4000_0000 + 32'(i), 1'b0, TAG_W'(10 + i), 1'b0, 1'b0, 1'b1);
            cycle();
        end
        check("t2_full_count", 32'(count), 32'd4);
        check("t2_full_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
            check("t2_pop_tag", 32'(out_tag), 32'(10 + i));
            cycle();
        end
        check("t2_empty", 32'(count), 32'd0);

        // Steady push+pop at occupancy 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h4100_0000, 1'b0, TAG_W'(20 + i), 1'b0, 1'b0, 1'b1);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h4100_0000, 1'b0, TAG_W'(22 + i), 1'b1, 1'b0, 1'b1);
            check("t3_tag", 32'(out_tag), 32'(20 + i));
            cycle();
        end
        check("t3_count", 32'(count), 32'd2);
        drain();

        // Overflow and NaN canonicalization
        drive(1'b1, 32'h7F80_0000, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'hFFC0_0000, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1);
        cycle();
        check("t4_data0", out_data, 32'h7F80_0000);
        check("t4_cls0", 32'(out_cls), 32'h080);
        drive(1'b0, 32'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle();
        check("t4_data1", out_data, 32'h7FC0_0000);
        check("t4_cls1", 32'(out_cls), 32'h200);
        check("t4_of", 32'(flag_of), 32'd1);
        check("t4_nv", 32'(flag_nv), 32'd1);
        drain();

        // Clear collides with a NaN push: set wins; then clear alone
        drive(1'b1, 32'h7F80_0001, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1);
        cycle();
        check("t5_nv_set_wins", 32'(flag_nv), 32'd1);
        check("t5_of_cleared", 32'(flag_of), 32'd0);
        check("t5_cls", 32'(out_cls), 32'h100);
        drive(1'b0, 32'd0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        cycle();
        check("t5_nv_clr", 32'(flag_nv), 32'd0);
        drain();

        // Reset with three entries queued, then push right after
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h7F80_0000, 1'(i == 0), TAG_W'(5 + i), 1'b0, 1'b0, 1'b1);
            cycle();
        end
        drive(1'b1, 32'h3F80_0000, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        cycle();
        check("t6_count", 32'(count), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_data", out_data, 32'd0);
        check("t6_of", 32'(flag_of), 32'd0);
        drive(1'b1, 32'h3F80_0000, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
        cycle();
        check("t6_push_count", 32'(count), 32'd1);
        check("t6_push_tag", 32'(out_tag), 32'd9);

        // Randomized traffic with shifting producer/consumer bias
        for (int blk = 0; blk < 40; blk++) begin
            int pv;
            int pr;
            pv = $urandom_range(1, 9);
            pr = $urandom_range(1, 9);
            for (int i = 0; i < 50; i++) begin
                drive(1'($urandom_range(0, 9) < pv), pick_y(), 1'($urandom_range(0, 7) == 0),
                      TAG_W'($urandom), 1'($urandom_range(0, 9) < pr),
                      1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) != 0));
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_result_queue.md
Name: fpu_result_queue

Overview:
- Downstream consumer of the combinational FP add/sub datapath. Accepts one result per cycle (32-bit single-precision value plus overflow flag) together with a destination tag.
- Canonicalizes special values and classifies each result.
- Buffers results in a small FIFO for the register-file writeback port, and keeps sticky exception flags for the FP status register.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- TAG_W, 5, width of destination register tag.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  synchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  queue can accept this cycle.
- in_y  input  32  IEEE-754 single result from add/sub datapath.
- in_ovf  input  1  overflow indicator accompanying in_y.
- in_tag  input  TAG_W  destination register tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback consumes head.
- out_data  output  32  canonicalized result at head.
- out_tag  output  TAG_W  tag at head.
- out_cls  output  10  one-hot class of head result.
- count  output  $clog2(DEPTH)+1  current occupancy.
- flags_clr  input  1  clear sticky flags.
- flag_of  output  1  sticky overflow.
- flag_nv  output  1  sticky NaN-produced (invalid).

Behaviour:

Reset (rstn=0 sampled at clk edge):
- count=0, read/write pointers=0, flag_of=0, flag_nv=0.
- Entry storage is not reset.
- Reset mid-operation discards all queued entries; no partial pop.

Handshake:
- in_ready = rstn && (count < DEPTH). It depends only on registered count; there is no pass-through when full, even if out_ready=1.
- push = in_valid && in_ready.
- out_valid = (count != 0).
- pop = out_valid && out_ready.

FIFO:
- Push writes mem[wptr] and increments wptr; pop increments rptr. Both pointers wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (legal whenever 0 < count < DEPTH).
- Latency: an entry pushed at edge N shows out_valid=1 in the cycle after edge N. There is no empty-queue bypass.
- While out_valid=0, out_data, out_tag and out_cls are forced to 0.

Write-path transform (computed combinationally from in_y/in_ovf and stored at push):
- Class from raw in_y (e = in_y[30:23], m = in_y[22:0], s = in_y[31]), one-hot:
  - bit0: -inf
  - bit1: -normal
  - bit2: -subnormal
  - bit3: -0
  - bit4: +0
  - bit5: +subnormal
  - bit6: +normal
  - bit7: +inf
  - bit8: sNaN (e=FF, m!=0, m[22]=0)
  - bit9: qNaN (e=FF, m[22]=1)
- If in_ovf=1, the class is overridden to +/-inf per s.
- Data:
  - If in_ovf=1: {s, 8'hFF, 23'b0}.
  - Else if NaN: 32'h7FC00000.
  - Else: in_y unchanged (subnormals kept).

Sticky flags:
- flag_of sets on a push with in_ovf=1.
- flag_nv sets on a push whose in_y is NaN.
- flags_clr=1 clears both flags at the edge.
- If flags_clr and a setting push occur in the same cycle, set wins.
- in_valid without in_ready has no effect on flags.

Timing:
- in_y to storage/flags is a combinational path; out_* come from storage through the read mux only. There is no other output combinational path from inputs except in_ready from rstn.

Test Plan:
- Reset then push in_y=32'h3F800000, tag=3, out_ready=0 -> next cycle out_valid=1, out_data=32'h3F800000, out_tag=3, out_cls=10'h040, count=1.
- Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is ignored; then out_ready=1 for 4 cycles pops tags in order, and count returns to 0 with pointers wrapped.
- Continuous push+pop at count=2 for 10 cycles -> count stays 2, ordering preserved across pointer wrap.
- Push in_y=32'h7F800000 with in_ovf=1, then push in_y=32'hFFC00000 -> out_data 7F800000 (cls 10'h080) then 7FC00000 (cls 10'h200); flag_of=1, flag_nv=1.
- flags_clr=1 in the same cycle as a push of in_y=32'h7F800001 -> flag_nv stays 1 (set wins) and out_cls=10'h100; flags_clr alone next cycle -> both flags 0.
- rstn=0 for one cycle with count=3 -> count=0, out_valid=0, out_data=0, flags 0; a push in the first cycle after reset is accepted normally.
